ppi_bus_ctrl: RTL and testbench

Bus-interface controller for the 8255-style parallel port block. It synchronises the asynchronous CPU strobes (cs_n, wr_n, rd_n) into the system clock domain and decodes writes into the port A/B/C output registers and the control word. It also applies port C bit set/reset commands and drives the direction controls and the read-back mux. It configures and sequences the port datapath that routes one input byte to one of four outputs.

---
 rtl/ppi_pkg.sv | 33 +++
 rtl/ppi_sync2.sv | 26 ++
 rtl/ppi_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ppi_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared constants for the 8255-style parallel port bus controller.
// Holds register addresses, the reset control word, control-word bit positions,
// the bus FSM state encoding and a helper that flags unsupported mode requests.
package ppi_pkg;

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_C    = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Mode 0, all ports input.
  localparam logic [7:0] CTRL_RST_DEFAULT = 8'h9B;

  localparam int MODE_SET_BIT = 7;
  localparam int DIR_A_BIT    = 4;
  localparam int DIR_CHI_BIT  = 3;
  localparam int DIR_B_BIT    = 1;
  localparam int DIR_CLO_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_CAP    = 2'd1,
    ST_WR_COMMIT = 2'd2,
    ST_RD        = 2'd3
  } state_t;

  // Only mode 0 is implemented: group A mode bits [6:5] and group B mode bit [2]
  // must be zero in a mode-set word.
  function automatic logic mode_unsupported(input logic [7:0] word);
    return (word[6:5] != 2'b00) || word[2];
  endfunction

endpackage

// File: rtl/ppi_sync2.sv
// ppi_sync2: single-bit synchroniser, STAGES flops deep, reset to RST_VAL.
// Ports: clk, reset_n (async active-low), d (async input), q (synchronised output).
// STAGES must be at least 2.
module ppi_sync2 #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: CPU bus interface of an 8255-style parallel port.
// Synchronises cs_n/wr_n/rd_n, decodes writes into port A/B/C output registers and
// the control word (mode set or port C bit set/reset), and drives direction
// controls plus a registered read-back mux.
// Ports: CPU side clk, reset_n, cs_n, wr_n, rd_n, addr, din, dout, dout_en;
//        pins port_*_in / port_*_out; status dir_*, ctrl_word, mode_err, wr_ack.
// Build option: define PPI_INPUT_SYNC_EN to pass the port input pins through
// 2-flop synchronisers ahead of the read mux (adds 2 clk of input latency).
module ppi_bus_ctrl
  import ppi_pkg::*;
#(
  parameter logic [7:0] CTRL_RST    = CTRL_RST_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic [7:0] port_a_in,
  input  logic [7:0] port_b_in,
  input  logic [7:0] port_c_in,
  output logic [7:0] port_a_out,
  output logic [7:0] port_b_out,
  output logic [7:0] port_c_out,
  output logic       dir_a,
  output logic       dir_b,
  output logic       dir_c_hi,
  output logic       dir_c_lo,
  output logic [7:0] ctrl_word,
  output logic       mode_err,
  output logic       wr_ack
);

  // Strobe synchronisers reset to 1 so the bus looks idle coming out of reset.
  logic cs_s, wr_s, rd_s;

  ppi_sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_n), .q(cs_s));
  ppi_sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk(clk), .reset_n(reset_n), .d(wr_n), .q(wr_s));
  ppi_sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk(clk), .reset_n(reset_n), .d(rd_n), .q(rd_s));

  // Pin values as seen by the read mux.
  logic [7:0] a_pin, b_pin, c_pin;

`ifdef PPI_INPUT_SYNC_EN
  for (genvar i = 0; i < 8; i++) begin : g_in_sync
    ppi_sync2 #(.STAGES(2), .RST_VAL(1'b0)) u_sync_a (
      .clk(clk), .reset_n(reset_n), .d(port_a_in[i]), .q(a_pin[i]));
    ppi_sync2 #(.STAGES(2), .RST_VAL(1'b0)) u_sync_b (
      .clk(clk), .reset_n(reset_n), .d(port_b_in[i]), .q(b_pin[i]));
    ppi_sync2 #(.STAGES(2), .RST_VAL(1'b0)) u_sync_c (
      .clk(clk), .reset_n(reset_n), .d(port_c_in[i]), .q(c_pin[i]));
  end
`else
  // The registered dout is the only sampling point of the pins.
  assign a_pin = port_a_in;
  assign b_pin = port_b_in;
  assign c_pin = port_c_in;
`endif

  // ---------------------------------------------------------------- FSM
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // Write wins when both strobes are low.
        if (!cs_s && !wr_s) begin
          state_nxt = ST_WR_CAP;
        end else if (!cs_s && !rd_s) begin
          state_nxt = ST_RD;
        end
      end
      ST_WR_CAP: begin
        if (wr_s) begin
          state_nxt = ST_WR_COMMIT;
        end else if (cs_s) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_COMMIT: state_nxt = ST_IDLE;
      ST_RD: begin
        if (!wr_s) begin
          state_nxt = ST_WR_CAP;
        end else if (rd_s || cs_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The register update happens on the edge that leaves WR_CAP, so the target
  // changes SYNC_STAGES+1 clocks after wr_n rises; wr_ack marks the following
  // cycle (the one spent in WR_COMMIT).
  logic wr_commit;
  assign wr_commit = (state == ST_WR_CAP) && wr_s;
  assign wr_ack    = (state == ST_WR_COMMIT);
  // Drop the read enable as soon as a write is seen, before the state moves.
  assign dout_en   = (state == ST_RD) && wr_s;

  // Capture on entry and on every cycle that stays in WR_CAP. The edge that
  // commits does not capture, so the committed value is the one sampled while
  // wr_n was still low.
  logic [1:0] cap_addr;
  logic [7:0] cap_din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_addr <= 2'd0;
      cap_din  <= 8'h00;
    end else if (state_nxt == ST_WR_CAP) begin
      cap_addr <= addr;
      cap_din  <= din;
    end
  end

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_a_out <= 8'h00;
      port_b_out <= 8'h00;
      port_c_out <= 8'h00;
      ctrl_word  <= CTRL_RST;
      mode_err   <= 1'b0;
    end else if (wr_commit) begin
      case (cap_addr)
        ADDR_A: port_a_out <= cap_din;
        ADDR_B: port_b_out <= cap_din;
        ADDR_C: port_c_out <= cap_din;
        ADDR_CTRL: begin
          if (cap_din[MODE_SET_BIT]) begin
            ctrl_word  <= cap_din;
            port_a_out <= 8'h00;
            port_b_out <= 8'h00;
            port_c_out <= 8'h00;
            if (mode_unsupported(cap_din)) begin
              mode_err <= 1'b1;
            end
          end else begin
            port_c_out[cap_din[3:1]] <= cap_din[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Directions only change on a mode set, which also loads ctrl_word from the
  // same bits, so decoding straight from ctrl_word is equivalent.
  assign dir_a    = ctrl_word[DIR_A_BIT];
  assign dir_b    = ctrl_word[DIR_B_BIT];
  assign dir_c_hi = ctrl_word[DIR_CHI_BIT];
  assign dir_c_lo = ctrl_word[DIR_CLO_BIT];

  // ------------------------------------------------------------ read mux
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_A:    rd_mux = dir_a ? a_pin : port_a_out;
      ADDR_B:    rd_mux = dir_b ? b_pin : port_b_out;
      ADDR_C:    rd_mux = {dir_c_hi ? c_pin[7:4] : port_c_out[7:4],
                           dir_c_lo ? c_pin[3:0] : port_c_out[3:0]};
      ADDR_CTRL: rd_mux = ctrl_word;
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= 8'h00;
    end else if (state == ST_RD) begin
      dout <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Self-checking bench for ppi_bus_ctrl: scenario tasks drive CPU bus cycles,
// push expected register/read values to a queue and compare them against the
// DUT once the corresponding write commit or read completes.
module tb_ppi_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n, wr_n, rd_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;
  logic [7:0] port_a_in, port_b_in, port_c_in;
  logic [7:0] port_a_out, port_b_out, port_c_out;
  logic       dir_a, dir_b, dir_c_hi, dir_c_lo;
  logic [7:0] ctrl_word;
  logic       mode_err;
  logic       wr_ack;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] want;

  always #5 clk = ~clk;

  ppi_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .din(din), .dout(dout), .dout_en(dout_en),
    .port_a_in(port_a_in), .port_b_in(port_b_in), .port_c_in(port_c_in),
    .port_a_out(port_a_out), .port_b_out(port_b_out), .port_c_out(port_c_out),
    .dir_a(dir_a), .dir_b(dir_b), .dir_c_hi(dir_c_hi), .dir_c_lo(dir_c_lo),
    .ctrl_word(ctrl_word), .mode_err(mode_err), .wr_ack(wr_ack)
  );

  // Each cycle wr_ack is seen high counts once; a stretched pulse counts twice.
  always @(negedge clk) if (wr_ack === 1'b1) ack_cnt++;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic en);
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    d = dout; en = dout_en;
    @(posedge clk); #1;
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    addr = 2'd0; din = 8'h00;
    port_a_in = 8'h00; port_b_in = 8'h00; port_c_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({port_a_out, port_b_out, port_c_out} !== 24'h0) begin
      n_err++; $display("FAIL reset_ports got %h want 000000", {port_a_out, port_b_out, port_c_out}); end
    n_cmp++; if (ctrl_word !== 8'h9B) begin
      n_err++; $display("FAIL reset_ctrl got %h want 9b", ctrl_word); end
    n_cmp++; if ({dir_a, dir_b, dir_c_hi, dir_c_lo} !== 4'hF) begin
      n_err++; $display("FAIL reset_dirs got %b want 1111", {dir_a, dir_b, dir_c_hi, dir_c_lo}); end
    n_cmp++; if ({dout_en, mode_err, wr_ack, dout} !== 11'h0) begin
      n_err++; $display("FAIL reset_status got en=%b err=%b ack=%b dout=%h want all 0",
                        dout_en, mode_err, wr_ack, dout); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_write;
    int ack0;
    ack0 = ack_cnt;
    exp_q.push_back(8'h80);
    bus_write(2'd3, 8'h80);
    want = exp_q.pop_front();
    n_cmp++; if (ctrl_word !== want) begin
      n_err++; $display("FAIL wr_ctrl got %h want %h", ctrl_word, want); end
    n_cmp++; if ({dir_a, dir_b, dir_c_hi, dir_c_lo} !== 4'h0) begin
      n_err++; $display("FAIL wr_dirs got %b want 0000", {dir_a, dir_b, dir_c_hi, dir_c_lo}); end
    // Latency: port A must still be old after SYNC_STAGES edges, new after one more.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    addr = 2'd0; din = 8'h5A; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    n_cmp++; if (port_a_out !== want) begin
      n_err++; $display("FAIL wr_lat_early got %h want %h", port_a_out, want); end
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    n_cmp++; if (port_a_out !== want || wr_ack !== 1'b1) begin
      n_err++; $display("FAIL wr_lat_edge got %h ack=%b want %h ack=1", port_a_out, wr_ack, want); end
    repeat (3) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
    n_cmp++; if (ack_cnt - ack0 !== 2) begin
      n_err++; $display("FAIL wr_ack_count got %0d want 2", ack_cnt - ack0); end
  endtask

  task automatic test_bit_set_reset;
    exp_q.push_back(8'h80);
    bus_write(2'd3, 8'h0F);
    want = exp_q.pop_front();
    n_cmp++; if (port_c_out !== want) begin
      n_err++; $display("FAIL bsr_set got %h want %h", port_c_out, want); end
    exp_q.push_back(8'h80);
    bus_write(2'd3, 8'h0A);
    want = exp_q.pop_front();
    n_cmp++; if (port_c_out !== want || ctrl_word !== 8'h80) begin
      n_err++; $display("FAIL bsr_reset got c=%h ctrl=%h want c=%h ctrl=80", port_c_out, ctrl_word, want); end
  endtask

  task automatic test_read;
    logic [7:0] d;
    logic       en;
    bus_write(2'd3, 8'h91);
    port_a_in = 8'hC3; port_b_in = 8'hFF; port_c_in = 8'h3C;
    bus_write(2'd2, 8'hA5);
    n_cmp++; if ({dir_a, dir_b, dir_c_hi, dir_c_lo} !== 4'b1001) begin
      n_err++; $display("FAIL rd_dirs got %b want 1001", {dir_a, dir_b, dir_c_hi, dir_c_lo}); end
    // A from pins, C high nibble from out reg (A), low nibble from pins (C),
    // B is output so reads port_b_out (cleared by the mode set), ctrl reads back.
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h91);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ra;
      ra = (i == 0) ? 2'd0 : (i == 1) ? 2'd2 : (i == 2) ? 2'd1 : 2'd3;
      bus_read(ra, d, en);
      want = exp_q.pop_front();
      n_cmp++; if (d !== want || en !== 1'b1) begin
        n_err++; $display("FAIL rd_addr%0d got %h en=%b want %h en=1", ra, d, en, want); end
    end
    @(negedge clk);
    n_cmp++; if (dout_en !== 1'b0 || dout !== 8'h91) begin
      n_err++; $display("FAIL rd_idle got en=%b dout=%h want en=0 dout=91", dout_en, dout); end
  endtask

  task automatic test_abort_mode_err;
    int ack0;
    ack0 = ack_cnt;
    exp_q.push_back(port_a_out);
    @(posedge clk); #1;
    addr = 2'd0; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    n_cmp++; if (port_a_out !== want || ack_cnt !== ack0) begin
      n_err++; $display("FAIL abort got a=%h acks=%0d want a=%h acks=0", port_a_out, ack_cnt - ack0, want); end
    bus_write(2'd3, 8'hA0);
    n_cmp++; if (mode_err !== 1'b1 || ctrl_word !== 8'hA0) begin
      n_err++; $display("FAIL mode_err_set got err=%b ctrl=%h want err=1 ctrl=a0", mode_err, ctrl_word); end
    exp_q.push_back(8'h11);
    bus_write(2'd0, 8'h11);
    bus_write(2'd3, 8'h80);
    bus_write(2'd0, 8'h11);
    want = exp_q.pop_front();
    n_cmp++; if (mode_err !== 1'b1 || port_a_out !== want) begin
      n_err++; $display("FAIL mode_err_sticky got err=%b a=%h want err=1 a=%h", mode_err, port_a_out, want); end
  endtask

  task automatic test_wr_rd_together;
    int   ack0;
    logic en_seen;
    ack0 = ack_cnt;
    en_seen = 1'b0;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    addr = 2'd1; din = 8'h3C; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (dout_en === 1'b1) en_seen = 1'b1;
      if (i == 5) begin
        @(posedge clk); #1 wr_n = 1'b1; rd_n = 1'b1;
      end
    end
    #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
    want = exp_q.pop_front();
    n_cmp++; if (port_b_out !== want || ack_cnt - ack0 !== 1) begin
      n_err++; $display("FAIL wr_rd_commit got b=%h acks=%0d want b=%h acks=1", port_b_out, ack_cnt - ack0, want); end
    n_cmp++; if (en_seen !== 1'b0) begin
      n_err++; $display("FAIL wr_rd_dout_en got %b want 0", en_seen); end
  endtask

  task automatic test_reset_mid_write;
    int ack0;
    @(posedge clk); #1;
    addr = 2'd0; din = 8'h99; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({port_a_out, port_b_out, port_c_out} !== 24'h0 || ctrl_word !== 8'h9B) begin
      n_err++; $display("FAIL rst_mid_regs got %h ctrl=%h want 000000 ctrl=9b",
                        {port_a_out, port_b_out, port_c_out}, ctrl_word); end
    n_cmp++; if (mode_err !== 1'b0 || {dir_a, dir_b, dir_c_hi, dir_c_lo} !== 4'hF || wr_ack !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_status got err=%b dirs=%b ack=%b want 0 1111 0",
                        mode_err, {dir_a, dir_b, dir_c_hi, dir_c_lo}, wr_ack); end
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(posedge clk);
    ack0 = ack_cnt;
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (port_a_out !== 8'h00 || ack_cnt !== ack0) begin
      n_err++; $display("FAIL rst_no_commit got a=%h acks=%0d want a=00 acks=0", port_a_out, ack_cnt - ack0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bit_set_reset();
    test_read();
    test_abort_mode_err();
    test_wr_rd_together();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
